// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: enable levels,
// register file geometry and the saturating counter helper.
`ifndef RF_WB_ARBITER_DEFS
`define RF_WB_ARBITER_DEFS
`define ENABLE  1'b1
`define DISABLE 1'b0
`endif

package rf_wb_arbiter_pkg;

  // Register file geometry: 32 entries of 32 bits.
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;

  // Writes to x0 are accepted but never reach the register file.
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  localparam int unsigned CNT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter. Scans requests starting at rr_ptr_i and
// wrapping; at most one grant bit is set. Reusable for any shared resource.
module rf_wb_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] upper_mask;
  logic [NUM_REQ-1:0] upper_req;
  logic               found;

  // Requests at or above the pointer take precedence over the wrapped ones.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      upper_mask[i] = (PTR_W'(i) >= rr_ptr_i);
    end
    upper_req = req_i & upper_mask;
  end

  // Lowest set bit of the upper half first, otherwise lowest set bit overall.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && upper_req[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the single register-file write port. Round-robin grant
// among NUM_REQ valid/ready requesters, winner registered and presented to the
// register file one cycle later, plus a saturating contention counter.
// Optional same-cycle forwarding from the output register: RF_WB_FWD_EN.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_num,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      reg_we,
  output logic [ADDR_W-1:0]         dstreg_num,
  output logic [DATA_W-1:0]         dstreg_data,
  output logic [15:0]               conflict_cnt
`ifdef RF_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0]         fwd_num1,
  input  logic [ADDR_W-1:0]         fwd_num2,
  output logic                      fwd_hit1,
  output logic                      fwd_hit2,
  output logic [DATA_W-1:0]         fwd_data1,
  output logic [DATA_W-1:0]         fwd_data2
`endif
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] req_elig;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [ADDR_W-1:0]  sel_num;
  logic [DATA_W-1:0]  sel_data;
  logic [2:0]         n_valid;
  logic               multi_valid;
  logic               we_d, we_q;
  logic [ADDR_W-1:0]  num_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   cnt_q;

  // No grants while held or while reset is asserted.
  always_comb begin
    req_elig = (rst && !wb_hold) ? req_valid : '0;
  end

  rf_wb_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i    (req_elig),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant)
  );

  // Winner index and its write payload.
  always_comb begin
    grant_idx = '0;
    sel_num   = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
        sel_num   = req_num[i*ADDR_W +: ADDR_W];
        sel_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
    grant_any = |grant;
    req_ready = grant;
  end

  // Next pointer is one past the winner; unchanged when nobody is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_any) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
    // A write to x0 completes its handshake but is suppressed at the port.
    we_d = (grant_any && (sel_num != ADDR_W'(REG_ZERO))) ? `ENABLE : `DISABLE;
  end

  // Contention: two or more requesters valid while not held.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      n_valid = n_valid + {2'b00, req_valid[i]};
    end
    multi_valid = (n_valid >= 3'd2);
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Output stage; num/data hold on idle cycles so only the enable drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q   <= `DISABLE;
      num_q  <= '0;
      data_q <= '0;
    end else begin
      we_q <= we_d;
      if (grant_any) begin
        num_q  <= sel_num;
        data_q <= sel_data;
      end
    end
  end

  // Saturating contention counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!wb_hold && multi_valid) begin
      cnt_q <= sat_inc(cnt_q);
    end
  end

  assign reg_we       = we_q;
  assign dstreg_num   = num_q;
  assign dstreg_data  = data_q;
  assign conflict_cnt = cnt_q;

`ifdef RF_WB_FWD_EN
  // Bypass the pending write to readers sampling the register file this cycle.
  always_comb begin
    fwd_hit1  = we_q && (num_q == fwd_num1);
    fwd_hit2  = we_q && (num_q == fwd_num2);
    fwd_data1 = fwd_hit1 ? data_q : '0;
    fwd_data2 = fwd_hit2 ? data_q : '0;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter (NUM_REQ=2): directed vector table,
// hand-written reset/forwarding sequences and randomized traffic against a
// behavioural model of the arbiter and register file.
module tb_rf_wb_arbiter;

  localparam int NUM_REQ = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_hold;
  logic [1:0]  req_valid;
  logic [9:0]  req_num;
  logic [63:0] req_data;
  logic [1:0]  req_ready;
  logic        reg_we;
  logic [4:0]  dstreg_num;
  logic [31:0] dstreg_data;
  logic [15:0] conflict_cnt;
`ifdef RF_WB_FWD_EN
  logic [4:0]  fwd_num1, fwd_num2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  rf_wb_arbiter #(
    .NUM_REQ (2),
    .DATA_W  (32),
    .ADDR_W  (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_hold      (wb_hold),
    .req_valid    (req_valid),
    .req_num      (req_num),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .reg_we       (reg_we),
    .dstreg_num   (dstreg_num),
    .dstreg_data  (dstreg_data),
    .conflict_cnt (conflict_cnt)
`ifdef RF_WB_FWD_EN
    ,
    .fwd_num1     (fwd_num1),
    .fwd_num2     (fwd_num2),
    .fwd_hit1     (fwd_hit1),
    .fwd_hit2     (fwd_hit2),
    .fwd_data1    (fwd_data1),
    .fwd_data2    (fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  // Register file as seen through the DUT write port.
  logic [31:0] rf [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (reg_we) rf[dstreg_num] <= dstreg_data;
  end

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_num = '0;
  logic [31:0] m_data = '0;
  logic [31:0] mrf [32] = '{default: 32'h0};
  int          last_g;
  logic [1:0]  last_ready;

  typedef struct {
    logic        hold;
    logic [1:0]  valid;
    logic [4:0]  n0, n1;
    logic [31:0] d0, d1;
    logic [1:0]  rdy;
    logic        we;
    logic [4:0]  num;
    logic [31:0] data;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(input logic hold, input logic [1:0] valid);
    if (hold || valid == 2'b00) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_cnt  = 0;
    m_we   = 1'b0;
    m_num  = '0;
    m_data = '0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic run_cycle(input logic hold, input logic [1:0] valid,
                           input logic [4:0] n0, input logic [4:0] n1,
                           input logic [31:0] d0, input logic [31:0] d1);
    logic [4:0]  n [2];
    logic [31:0] d [2];
    int          g;
    logic [1:0]  exp_ready;
    n[0] = n0; n[1] = n1; d[0] = d0; d[1] = d1;
    wb_hold   = hold;
    req_valid = valid;
    req_num   = {n1, n0};
    req_data  = {d1, d0};
    #1;
    g = model_grant(hold, valid);
    exp_ready = (g >= 0) ? 2'(2'b01 << g) : 2'b00;
    last_g     = g;
    last_ready = req_ready;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (m_we) mrf[m_num] = m_data;
    if (g >= 0) begin
      m_we   = (n[g] != 5'd0);
      m_num  = n[g];
      m_data = d[g];
      m_ptr  = (g + 1) % NUM_REQ;
    end else begin
      m_we = 1'b0;
    end
    if (!hold && $countones(valid) >= 2 && m_cnt < 65535) m_cnt++;
    #1;
    check("reg_we", 32'(reg_we), 32'(m_we));
    check("dstreg_num", 32'(dstreg_num), 32'(m_num));
    check("dstreg_data", dstreg_data, m_data);
    check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
    @(negedge clk);
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        pv [2];
    logic [4:0]  pn [2];
    logic [31:0] pd [2];

    // hold, valid, n0, n1, d0, d1 | ready, we, num, data, cnt
    tbl[0]  = '{1'b0, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1, 2'b01, 1'b1, 5'd3, 32'hA0, 16'd1};
    tbl[1]  = '{1'b0, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1, 2'b10, 1'b1, 5'd4, 32'hB1, 16'd2};
    tbl[2]  = '{1'b0, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1, 2'b01, 1'b1, 5'd3, 32'hA0, 16'd3};
    tbl[3]  = '{1'b0, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1, 2'b10, 1'b1, 5'd4, 32'hB1, 16'd4};
    tbl[4]  = '{1'b0, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b01, 1'b1, 5'd5, 32'hDEADBEEF,
                16'd4};
    tbl[5]  = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd5, 32'hDEADBEEF, 16'd4};
    tbl[6]  = '{1'b0, 2'b10, 5'd0, 5'd0, 32'h0, 32'h1234, 2'b10, 1'b0, 5'd0, 32'h1234, 16'd4};
    tbl[7]  = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 32'h1234, 16'd4};
    tbl[8]  = '{1'b0, 2'b01, 5'd9, 5'd0, 32'h99, 32'h0, 2'b01, 1'b1, 5'd9, 32'h99, 16'd4};
    tbl[9]  = '{1'b1, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1, 2'b00, 1'b0, 5'd9, 32'h99, 16'd4};
    tbl[10] = '{1'b1, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1, 2'b00, 1'b0, 5'd9, 32'h99, 16'd4};
    tbl[11] = '{1'b1, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1, 2'b00, 1'b0, 5'd9, 32'h99, 16'd4};
    tbl[12] = '{1'b0, 2'b11, 5'd3, 5'd4, 32'hA0, 32'hB1, 2'b10, 1'b1, 5'd4, 32'hB1, 16'd5};
    tbl[13] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd4, 32'hB1, 16'd5};

    // Reset with both requesters valid.
    rst       = 1'b0;
    wb_hold   = 1'b0;
    req_valid = 2'b11;
    req_num   = {5'd4, 5'd3};
    req_data  = {32'hB1, 32'hA0};
`ifdef RF_WB_FWD_EN
    fwd_num1 = 5'd0;
    fwd_num2 = 5'd0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'h0);
    check("reset reg_we", 32'(reg_we), 32'h0);
    check("reset conflict_cnt", 32'(conflict_cnt), 32'h0);
    check("reset dstreg_num", 32'(dstreg_num), 32'h0);
    check("reset dstreg_data", dstreg_data, 32'h0);
    rst = 1'b1;
    model_reset();

    // Directed vectors: contention, single write, x0 write, hold.
    for (int i = 0; i < 14; i++) begin
      run_cycle(tbl[i].hold, tbl[i].valid, tbl[i].n0, tbl[i].n1, tbl[i].d0, tbl[i].d1);
      check($sformatf("vec%0d ready", i), 32'(last_ready), 32'(tbl[i].rdy));
      check($sformatf("vec%0d we", i), 32'(reg_we), 32'(tbl[i].we));
      check($sformatf("vec%0d num", i), 32'(dstreg_num), 32'(tbl[i].num));
      check($sformatf("vec%0d data", i), dstreg_data, tbl[i].data);
      check($sformatf("vec%0d cnt", i), 32'(conflict_cnt), 32'(tbl[i].cnt));
    end

    // Same-index collision: later grant's data must be the surviving value.
    run_cycle(1'b0, 2'b11, 5'd12, 5'd12, 32'h1111, 32'h2222);
    run_cycle(1'b0, 2'b10, 5'd12, 5'd12, 32'h1111, 32'h2222);
    run_cycle(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    run_cycle(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    check("collision x12", rf[12], 32'h2222);

`ifdef RF_WB_FWD_EN
    fwd_num1 = 5'd7;
    fwd_num2 = 5'd8;
    run_cycle(1'b0, 2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0);
    check("fwd_hit1", 32'(fwd_hit1), 32'h1);
    check("fwd_data1", fwd_data1, 32'hA5A5A5A5);
    check("fwd_hit2", 32'(fwd_hit2), 32'h0);
    check("fwd_data2", fwd_data2, 32'h0);
`endif

    // Randomized traffic; requesters keep payload stable until granted
    // but may occasionally withdraw.
    for (int i = 0; i < NUM_REQ; i++) begin
      pv[i] = 1'b0; pn[i] = '0; pd[i] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      logic hold;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pv[i] && ($urandom % 3 == 0)) begin
          pv[i] = 1'b1;
          pn[i] = 5'($urandom % 8);
          pd[i] = $urandom;
        end else if (pv[i] && ($urandom % 16 == 0)) begin
          pv[i] = 1'b0;
        end
      end
      hold = ($urandom % 5 == 0);
      run_cycle(hold, {pv[1], pv[0]}, pn[0], pn[1], pd[0], pd[1]);
      if (last_g >= 0) pv[last_g] = 1'b0;
    end

    // Reset while a write is pending: the write is discarded.
    run_cycle(1'b0, 2'b01, 5'd6, 5'd0, 32'h66, 32'h0);
    req_valid = 2'b11;
    rst = 1'b0;
    #1;
    check("midrst reg_we", 32'(reg_we), 32'h0);
    check("midrst req_ready", 32'(req_ready), 32'h0);
    check("midrst conflict_cnt", 32'(conflict_cnt), 32'h0);
    check("midrst dstreg_num", 32'(dstreg_num), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run_cycle(1'b0, 2'b11, 5'd1, 5'd2, 32'h10, 32'h20);
    check("post-reset grant", 32'(last_ready), 32'h1);
    run_cycle(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    run_cycle(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

    // Register file contents against the model; x0 must never be written.
    check("x0 stays zero", rf[0], 32'h0);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("rf[%0d]", i), rf[i], mrf[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
